// File: rtl/wb_queue_stage_pkg.sv
// Shared constants for the 8051 write-back queue: SFR addresses, flag bit
// order {ov, ac, cy} and the bit positions of each queue entry field.
package wb_queue_stage_pkg;

    // SFR map
    localparam logic [7:0] PSW_ADDR_DEF = 8'hD0;
    localparam logic [7:0] SFR_BASE_DEF = 8'h80;

    // PSW flag bits inside the 3-bit flags vector {ov, ac, cy}
    localparam int unsigned FLAGS_W  = 3;
    localparam int unsigned FLAG_CY  = 0;
    localparam int unsigned FLAG_AC  = 1;
    localparam int unsigned FLAG_OV  = 2;

    // Entry layout, LSB first: is_sfr, flag_we, we, flags, data, addr
    localparam int unsigned IS_SFR_POS  = 0;
    localparam int unsigned FLAG_WE_POS = 1;
    localparam int unsigned WE_POS      = 2;
    localparam int unsigned FLAGS_POS   = 3;
    localparam int unsigned DATA_POS    = FLAGS_POS + FLAGS_W;

    // Address field sits directly above the data field
    function automatic int unsigned addr_pos(input int unsigned data_w);
        return DATA_POS + data_w;
    endfunction

    // Total entry width for a given data/address width
    function automatic int unsigned entry_w(input int unsigned data_w, input int unsigned addr_w);
        return DATA_POS + data_w + addr_w;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// In-order storage for the write-back queue: entry RAM, wrapping pointers,
// occupancy count and registered status flags. Full refuses pushes even
// when a pop happens in the same cycle.
module wb_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic                         pop,
    input  logic [WIDTH-1:0]             wdata,
    output logic [WIDTH-1:0]             head,
    output logic [DEPTH*WIDTH-1:0]       mem_flat,
    output logic [$clog2(DEPTH)-1:0]     rd_ptr,
    output logic [$clog2(DEPTH):0]       count,
    output logic                         full,
    output logic                         empty,
    output logic                         ready
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full_q, empty_q, ready_q;
    logic             do_push, do_pop;

    // Qualify requests against the registered status
    always_comb begin
        do_push = push && !full_q;
        do_pop  = pop && !empty_q;
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // Pointers, count and status registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            ready_q  <= 1'b1;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_d;
            full_q  <= (count_d == CNT_W'(DEPTH));
            empty_q <= (count_d == '0);
            ready_q <= (count_d != CNT_W'(DEPTH));
        end
    end

    // Entry storage; validity is tracked by the count, not the contents
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= wdata;
    end

    // Flattened view of all slots for the forwarding lookup
    always_comb begin
        mem_flat = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_flat[i*WIDTH +: WIDTH] = mem[i];
        end
    end

    assign head   = mem[rd_ptr_q];
    assign rd_ptr = rd_ptr_q;
    assign count  = count_q;
    assign full   = full_q;
    assign empty  = empty_q;
    assign ready  = ready_q;

endmodule

// File: rtl/wb_queue_stage.sv
// 8051 write-back stage: registered in-order write queue draining to the
// RAM and SFR write ports, with PSW flag updates riding on their entry.
// Optional feature macro WB_FORWARD_EN builds the pending-write forwarding
// lookup; without it o_fwd_hit/o_fwd_data are tied to zero.
module wb_queue_stage
    import wb_queue_stage_pkg::*;
#(
    parameter int unsigned          DATA_W   = 8,
    parameter int unsigned          ADDR_W   = 8,
    parameter int unsigned          DEPTH    = 4,
    parameter logic [ADDR_W-1:0]    SFR_BASE = ADDR_W'(SFR_BASE_DEF),
    parameter logic [ADDR_W-1:0]    PSW_ADDR = ADDR_W'(PSW_ADDR_DEF)
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_valid,
    output logic                     o_ready,
    input  logic [ADDR_W-1:0]        i_addr,
    input  logic [DATA_W-1:0]        i_data,
    input  logic                     i_we,
    input  logic                     i_flag_we,
    input  logic [2:0]               i_flags,
    output logic                     o_ram_wr_valid,
    input  logic                     i_ram_wr_ready,
    output logic                     o_sfr_wr_valid,
    input  logic                     i_sfr_wr_ready,
    output logic [ADDR_W-1:0]        o_wr_addr,
    output logic [DATA_W-1:0]        o_wr_data,
    output logic                     o_psw_flags_we,
    output logic [2:0]               o_psw_flags,
    input  logic [ADDR_W-1:0]        i_fwd_addr,
    output logic                     o_fwd_hit,
    output logic [DATA_W-1:0]        o_fwd_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int unsigned PTR_W    = $clog2(DEPTH);
    localparam int unsigned CNT_W    = PTR_W + 1;
    localparam int unsigned ADDR_POS = addr_pos(DATA_W);
    localparam int unsigned ENTRY_W  = entry_w(DATA_W, ADDR_W);

    logic [ENTRY_W-1:0]       entry_in, head;
    logic [DEPTH*ENTRY_W-1:0] mem_flat;
    logic [PTR_W-1:0]         rd_ptr;
    logic [CNT_W-1:0]         count;
    logic                     full, empty, ready;
    logic                     push, pop;
    logic                     ram_valid, sfr_valid;

    logic                     h_we, h_flag_we, h_is_sfr;
    logic [FLAGS_W-1:0]       h_flags;
    logic [DATA_W-1:0]        h_data;
    logic [ADDR_W-1:0]        h_addr;

    // Pack an incoming request; requests with no write at all are dropped
    always_comb begin
        entry_in                                = '0;
        entry_in[IS_SFR_POS]                    = (i_addr >= SFR_BASE);
        entry_in[FLAG_WE_POS]                   = i_flag_we;
        entry_in[WE_POS]                        = i_we;
        entry_in[FLAGS_POS +: FLAGS_W]          = i_flags;
        entry_in[DATA_POS +: DATA_W]            = i_data;
        entry_in[ADDR_POS +: ADDR_W]            = i_addr;
        push = i_valid && ready && (i_we || i_flag_we);
    end

    wb_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (i_clk),
        .rst_n    (i_rst_n),
        .push     (push),
        .pop      (pop),
        .wdata    (entry_in),
        .head     (head),
        .mem_flat (mem_flat),
        .rd_ptr   (rd_ptr),
        .count    (count),
        .full     (full),
        .empty    (empty),
        .ready    (ready)
    );

    // Head dispatch: byte writes by address class, flag-only entries to PSW
    always_comb begin
        h_is_sfr  = head[IS_SFR_POS];
        h_flag_we = head[FLAG_WE_POS];
        h_we      = head[WE_POS];
        h_flags   = head[FLAGS_POS +: FLAGS_W];
        h_data    = head[DATA_POS +: DATA_W];
        h_addr    = head[ADDR_POS +: ADDR_W];

        ram_valid      = !empty && h_we && !h_is_sfr;
        sfr_valid      = !empty && !(h_we && !h_is_sfr);
        o_wr_addr      = '0;
        o_wr_data      = '0;
        if (!empty) begin
            o_wr_addr = h_we ? h_addr : PSW_ADDR;
            o_wr_data = h_we ? h_data : '0;
        end
        pop            = (ram_valid && i_ram_wr_ready) || (sfr_valid && i_sfr_wr_ready);
        o_psw_flags_we = pop && h_flag_we;
        o_psw_flags    = o_psw_flags_we ? h_flags : 3'b000;
    end

`ifdef WB_FORWARD_EN
    // Youngest pending byte write to the lookup address wins
    always_comb begin
        logic [PTR_W-1:0]   slot;
        logic [ENTRY_W-1:0] ent;
        o_fwd_hit  = 1'b0;
        o_fwd_data = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            slot = rd_ptr + PTR_W'(i);
            ent  = mem_flat[32'(slot)*ENTRY_W +: ENTRY_W];
            if ((32'(i) < 32'(count)) && ent[WE_POS] &&
                (ent[ADDR_POS +: ADDR_W] == i_fwd_addr)) begin
                o_fwd_hit  = 1'b1;
                o_fwd_data = ent[DATA_POS +: DATA_W];
            end
        end
    end
`else
    // Forwarding not built: earlier stages must stall on hazards
    logic unused_fwd;
    assign unused_fwd = ^{i_fwd_addr, mem_flat, rd_ptr};
    assign o_fwd_hit  = 1'b0;
    assign o_fwd_data = '0;
`endif

    assign o_ready        = ready;
    assign o_full         = full;
    assign o_empty        = empty;
    assign o_count        = count;
    assign o_ram_wr_valid = ram_valid;
    assign o_sfr_wr_valid = sfr_valid;

endmodule

// File: tb/tb_wb_queue_stage.sv
// Directed bench for wb_queue_stage: RAM/SFR/flag-only dispatch, stalls,
// full/refusal and wrap, forwarding and asynchronous reset mid-handshake.
module tb_wb_queue_stage;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       valid, we, flag_we;
    logic [7:0] addr, data, fwd_addr;
    logic [2:0] flags;
    logic       ram_ready, sfr_ready;
    logic       ready, ram_valid, sfr_valid, psw_we, fwd_hit, full, empty;
    logic [7:0] wr_addr, wr_data, fwd_data;
    logic [2:0] psw_flags;
    logic [2:0] count;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    wb_queue_stage dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_valid        (valid),
        .o_ready        (ready),
        .i_addr         (addr),
        .i_data         (data),
        .i_we           (we),
        .i_flag_we      (flag_we),
        .i_flags        (flags),
        .o_ram_wr_valid (ram_valid),
        .i_ram_wr_ready (ram_ready),
        .o_sfr_wr_valid (sfr_valid),
        .i_sfr_wr_ready (sfr_ready),
        .o_wr_addr      (wr_addr),
        .o_wr_data      (wr_data),
        .o_psw_flags_we (psw_we),
        .o_psw_flags    (psw_flags),
        .i_fwd_addr     (fwd_addr),
        .o_fwd_hit      (fwd_hit),
        .o_fwd_data     (fwd_data),
        .o_full         (full),
        .o_empty        (empty),
        .o_count        (count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present a request right after a negedge, leave it for one edge
    task automatic req(input logic [7:0] a, input logic [7:0] d,
                       input logic w, input logic fw, input logic [2:0] f);
        valid = 1'b1; addr = a; data = d; we = w; flag_we = fw; flags = f;
        @(negedge clk);
        valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic exp_hit;
        rst_n = 1'b0; valid = 1'b0; we = 1'b0; flag_we = 1'b0; flags = 3'b000;
        addr = 8'h00; data = 8'h00; fwd_addr = 8'h00;
        ram_ready = 1'b0; sfr_ready = 1'b0;
`ifdef WB_FORWARD_EN
        exp_hit = 1'b1;
`else
        exp_hit = 1'b0;
`endif

        // Reset state
        #12;
        check("rst_ready", ready, 1);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_count", count, 0);
        check("rst_valids", {ram_valid, sfr_valid}, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_psw_we", psw_we, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Single RAM write, drains on the next edge
        ram_ready = 1'b1;
        req(8'h30, 8'hA5, 1'b1, 1'b0, 3'b000);
        check("ram_count1", count, 1);
        check("ram_valid", ram_valid, 1);
        check("ram_no_sfr", sfr_valid, 0);
        check("ram_addr", wr_addr, 8'h30);
        check("ram_data", wr_data, 8'hA5);
        @(negedge clk);
        check("ram_count0", count, 0);
        check("ram_valid_off", ram_valid, 0);
        check("ram_empty", empty, 1);

        // SFR write held off for three edges, retires on the fourth
        sfr_ready = 1'b0;
        req(8'hA8, 8'h5A, 1'b1, 1'b0, 3'b000);
        for (int i = 0; i < 4; i++) begin
            check("sfr_valid_hold", sfr_valid, 1);
            check("sfr_ram_quiet", ram_valid, 0);
            check("sfr_addr_hold", wr_addr, 8'hA8);
            check("sfr_data_hold", wr_data, 8'h5A);
            check("sfr_count_hold", count, 1);
            if (i == 3) sfr_ready = 1'b1;
            @(negedge clk);
        end
        check("sfr_empty", empty, 1);
        check("sfr_valid_off", sfr_valid, 0);

        // Flag-only ALU update goes to PSW with zero data
        sfr_ready = 1'b0;
        req(8'h12, 8'h77, 1'b0, 1'b1, 3'b101);
        check("flg_sfr_valid", sfr_valid, 1);
        check("flg_ram_quiet", ram_valid, 0);
        check("flg_addr", wr_addr, 8'hD0);
        check("flg_data", wr_data, 8'h00);
        check("flg_no_pulse", psw_we, 0);
        sfr_ready = 1'b1;
        #1;
        check("flg_pulse", psw_we, 1);
        check("flg_flags", psw_flags, 3'b101);
        @(negedge clk);
        check("flg_empty", empty, 1);
        check("flg_pulse_off", psw_we, 0);

        // A request with no write is accepted and dropped
        req(8'h33, 8'h44, 1'b0, 1'b0, 3'b111);
        check("nop_count", count, 0);
        check("nop_empty", empty, 1);

        // Fill with ports stalled; pointers wrap past the end
        ram_ready = 1'b0; sfr_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            req(8'h50 + 8'(i), 8'hE0 + 8'(i), 1'b1, 1'b0, 3'b000);
        end
        check("fill_full", full, 1);
        check("fill_ready", ready, 0);
        check("fill_count", count, 4);
        check("fill_head", wr_addr, 8'h50);
        // Fifth request arrives while the head pops: refused
        valid = 1'b1; addr = 8'h5F; data = 8'hFF; we = 1'b1; flag_we = 1'b0;
        ram_ready = 1'b1;
        #1;
        check("full_pop_head", wr_data, 8'hE0);
        @(negedge clk);
        valid = 1'b0;
        check("full_refused_count", count, 3);
        for (int i = 1; i < 4; i++) begin
            check("drain_addr", wr_addr, 8'h50 + 8'(i));
            check("drain_data", wr_data, 8'hE0 + 8'(i));
            @(negedge clk);
        end
        check("drain_empty", empty, 1);
        check("drain_ready", ready, 1);

        // Back-to-back push and pop keep one entry in flight
        req(8'h61, 8'h01, 1'b1, 1'b0, 3'b000);
        req(8'h62, 8'h02, 1'b1, 1'b0, 3'b000);
        check("stream_count", count, 1);
        check("stream_head", wr_addr, 8'h62);
        @(negedge clk);
        check("stream_empty", empty, 1);

        // Forwarding: youngest matching byte write wins
        ram_ready = 1'b0;
        req(8'h40, 8'h11, 1'b1, 1'b0, 3'b000);
        req(8'h40, 8'h22, 1'b1, 1'b0, 3'b000);
        req(8'h41, 8'h33, 1'b1, 1'b0, 3'b000);
        fwd_addr = 8'h40;
        #1;
        check("fwd40_hit", fwd_hit, exp_hit);
        check("fwd40_data", fwd_data, exp_hit ? 8'h22 : 8'h00);
        fwd_addr = 8'h41;
        #1;
        check("fwd41_data", fwd_data, exp_hit ? 8'h33 : 8'h00);
        fwd_addr = 8'h42;
        #1;
        check("fwd42_miss", fwd_hit, 0);
        ram_ready = 1'b1;
        @(negedge clk); @(negedge clk); @(negedge clk);
        check("fwd_drained", empty, 1);
        fwd_addr = 8'h40;
        #1;
        check("fwd_gone", fwd_hit, 0);

        // Asynchronous reset while an SFR write is stalled
        sfr_ready = 1'b0;
        req(8'hB0, 8'h9C, 1'b1, 1'b0, 3'b000);
        check("mid_valid", sfr_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", sfr_valid, 0);
        check("mid_rst_addr", wr_addr, 0);
        check("mid_rst_count", count, 0);
        check("mid_rst_empty", empty, 1);
        check("mid_rst_ready", ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        sfr_ready = 1'b1;
        @(negedge clk);
        check("post_rst_empty", empty, 1);
        check("post_rst_valid", sfr_valid, 0);
        check("post_rst_psw", psw_we, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
